// File: rtl/plic_pkg.sv
// Shared address map and helpers for the plic_prio interrupt controller.
package plic_pkg;

  localparam int unsigned PRIO_BASE   = 32'h0000_0000;
  localparam int unsigned PEND_BASE   = 32'h0000_1000;
  localparam int unsigned ENAB_BASE   = 32'h0000_2000;
  localparam int unsigned ENAB_STRIDE = 32'h0000_0080;
  localparam int unsigned CTX_BASE    = 32'h0020_0000;
  localparam int unsigned CTX_STRIDE  = 32'h0000_1000;
  localparam int unsigned CLAIM_OFS   = 32'h0000_0004;

  // Width able to hold IDs 0..n, where 0 means "no interrupt".
  function automatic int unsigned id_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/plic_arbiter.sv
// Per-context winner search: highest priority above threshold, lowest ID on ties.
module plic_arbiter
  import plic_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned PRIO_W = 3,
  parameter int unsigned ID_W   = id_width(N)
) (
  input  logic [N-1:0]        cand,
  input  logic [N*PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]   thr,
  output logic [ID_W-1:0]     winner
);

  logic [PRIO_W-1:0] best;

  // Seeding with the threshold makes "above threshold" and "beats best" one test;
  // strict compare keeps the earlier (lower) ID on a tie.
  always_comb begin
    best   = thr;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && (prio[i*PRIO_W +: PRIO_W] > best)) begin
        best   = prio[i*PRIO_W +: PRIO_W];
        winner = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/plic_prio.sv
// Platform-level interrupt controller with per-source priority and per-context claim.
// Optional build macro: PLIC_EDGE_TRIG_EN selects rising-edge instead of level gateways.
module plic_prio
  import plic_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned CTX    = 1,
  parameter int unsigned PRIO_W = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [31:0]    ADDR,
  input  logic [31:0]    WDATA,
  input  logic [3:0]     WE,
  input  logic           RE,
  output logic [31:0]    RDATA,
  output logic [CTX-1:0] EX_INT,
  input  logic [N-1:0]   interrupts
);

  localparam int unsigned ID_W = id_width(N);

  logic [N-1:0][PRIO_W-1:0]   prio_q, prio_d;
  logic [CTX-1:0][N-1:0]      en_q, en_d;
  logic [CTX-1:0][PRIO_W-1:0] thr_q, thr_d;
  logic [N-1:0]               pend_q, pend_d, fly_q, fly_d;
  logic [N-1:0]               gw_set, claim_mask, comp_mask;
  logic [CTX-1:0][ID_W-1:0]   winner;
  logic [CTX-1:0]             ex_int_q, ex_int_d;
  logic [31:0]                rdata_q, rdata_d, rd_val, byte_mask;
  logic [23:0]                a;
  logic [N-1:0]               prio_sel;
  logic                       pend_sel;
  logic [CTX-1:0]             en_sel, thr_sel, clm_sel;
  logic                       unused_sig;

  assign a          = ADDR[23:0];
  assign unused_sig = ^{ADDR[31:24], WDATA};
  assign byte_mask  = {{8{WE[3]}}, {8{WE[2]}}, {8{WE[1]}}, {8{WE[0]}}};

  // Exact-match decode: misaligned, ID 0, ID > N and ctx >= CTX all fall through to 0.
  always_comb begin
    prio_sel = '0;
    en_sel   = '0;
    thr_sel  = '0;
    clm_sel  = '0;
    pend_sel = (a == 24'(PEND_BASE));
    for (int k = 0; k < N; k++) begin
      prio_sel[k] = (a == 24'(PRIO_BASE + 4 * (k + 1)));
    end
    for (int c = 0; c < CTX; c++) begin
      en_sel[c]  = (a == 24'(ENAB_BASE + ENAB_STRIDE * c));
      thr_sel[c] = (a == 24'(CTX_BASE + CTX_STRIDE * c));
      clm_sel[c] = (a == 24'(CTX_BASE + CTX_STRIDE * c + CLAIM_OFS));
    end
  end

`ifdef PLIC_EDGE_TRIG_EN
  logic [N-1:0] src_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) src_q <= '0;
    else      src_q <= interrupts;
  end

  assign gw_set = interrupts & ~src_q & ~fly_q;
`else
  assign gw_set = interrupts & ~fly_q;
`endif

  for (genvar c = 0; c < CTX; c++) begin : g_arb
    plic_arbiter #(
      .N      (N),
      .PRIO_W (PRIO_W),
      .ID_W   (ID_W)
    ) u_arb (
      .cand   (pend_q & en_q[c]),
      .prio   (prio_q),
      .thr    (thr_q[c]),
      .winner (winner[c])
    );
  end

  always_comb begin
    claim_mask = '0;
    comp_mask  = '0;
    for (int c = 0; c < CTX; c++) begin
      for (int i = 0; i < N; i++) begin
        if (RE && clm_sel[c] && (winner[c] == ID_W'(i + 1))) claim_mask[i] = 1'b1;
        if (WE[0] && clm_sel[c] && (WDATA[5:0] == 6'(i + 1))) comp_mask[i] = 1'b1;
      end
    end
  end

  // A claim in the same cycle as a source (re)assert wins: pending clears, in_flight sets.
  always_comb begin
    pend_d = (pend_q | gw_set) & ~claim_mask;
    fly_d  = (fly_q & ~comp_mask) | claim_mask;
    prio_d = prio_q;
    en_d   = en_q;
    thr_d  = thr_q;
    for (int k = 0; k < N; k++) begin
      if (WE[0] && prio_sel[k]) prio_d[k] = WDATA[PRIO_W-1:0];
    end
    for (int c = 0; c < CTX; c++) begin
      if (en_sel[c]) begin
        en_d[c] = (en_q[c] & ~byte_mask[N-1:0]) | (WDATA[N-1:0] & byte_mask[N-1:0]);
      end
      if (WE[0] && thr_sel[c]) thr_d[c] = WDATA[PRIO_W-1:0];
      ex_int_d[c] = |winner[c];
    end
  end

  always_comb begin
    rd_val = '0;
    if (pend_sel) rd_val = 32'(pend_q);
    for (int k = 0; k < N; k++) begin
      if (prio_sel[k]) rd_val = 32'(prio_q[k]);
    end
    for (int c = 0; c < CTX; c++) begin
      if (en_sel[c])  rd_val = 32'(en_q[c]);
      if (thr_sel[c]) rd_val = 32'(thr_q[c]);
      if (clm_sel[c]) rd_val = 32'(winner[c]);
    end
    rdata_d = RE ? rd_val : '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prio_q   <= '0;
      en_q     <= '0;
      thr_q    <= '0;
      pend_q   <= '0;
      fly_q    <= '0;
      ex_int_q <= '0;
      rdata_q  <= '0;
    end else begin
      prio_q   <= prio_d;
      en_q     <= en_d;
      thr_q    <= thr_d;
      pend_q   <= pend_d;
      fly_q    <= fly_d;
      ex_int_q <= ex_int_d;
      rdata_q  <= rdata_d;
    end
  end

  assign EX_INT = ex_int_q;
  assign RDATA  = rdata_q;

endmodule

// File: tb/tb_plic_prio.sv
// Randomised bench for plic_prio against a behavioural model of the register map and gateways.
module tb_plic_prio;

  localparam int N      = 32;
  localparam int CTX    = 2;
  localparam int PRIO_W = 3;

  logic           clk;
  logic           rst_n;
  logic [31:0]    addr;
  logic [31:0]    wdata;
  logic [3:0]     we;
  logic           re;
  logic [31:0]    rdata;
  logic [CTX-1:0] ex_int;
  logic [N-1:0]   src;

  int n_cmp;
  int n_err;

  // Behavioural model state, indexed by ID (1..N) and context.
  int          m_prio [1:N];
  bit          m_pend [1:N];
  bit          m_fly  [1:N];
  bit          m_prev [1:N];
  int          m_thr  [CTX];
  logic [31:0] m_en   [CTX];

  plic_prio #(
    .N      (N),
    .CTX    (CTX),
    .PRIO_W (PRIO_W)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .ADDR       (addr),
    .WDATA      (wdata),
    .WE         (we),
    .RE         (re),
    .RDATA      (rdata),
    .EX_INT     (ex_int),
    .interrupts (src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int prio_addr(input int id);
    return 4 * id;
  endfunction
  function automatic int en_addr(input int c);
    return 'h2000 + 'h80 * c;
  endfunction
  function automatic int thr_addr(input int c);
    return 'h200000 + 'h1000 * c;
  endfunction
  function automatic int clm_addr(input int c);
    return 'h200004 + 'h1000 * c;
  endfunction

  function automatic int ctx_of(input logic [23:0] a, input int base, input int stride);
    for (int c = 0; c < CTX; c++) begin
      if (int'(a) == base + stride * c) return c;
    end
    return -1;
  endfunction

  function automatic bit is_cand(input int c, input int id);
    return m_pend[id] && m_en[c][id-1] && (m_prio[id] > m_thr[c]);
  endfunction

  // Find the top priority among candidates, then the lowest ID holding it.
  function automatic int model_winner(input int c);
    int maxp;
    maxp = -1;
    for (int id = 1; id <= N; id++) begin
      if (is_cand(c, id) && m_prio[id] > maxp) maxp = m_prio[id];
    end
    if (maxp < 0) return 0;
    for (int id = 1; id <= N; id++) begin
      if (is_cand(c, id) && m_prio[id] == maxp) return id;
    end
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [23:0] a);
    int ai;
    int c;
    logic [31:0] w;
    ai = int'(a);
    if (a[1:0] != 2'b00) return 32'h0;
    if (ai < 'h1000) return (ai >= 4 && ai <= 4 * N) ? 32'(m_prio[ai/4]) : 32'h0;
    if (ai == 'h1000) begin
      w = '0;
      for (int id = 1; id <= N; id++) w[id-1] = m_pend[id];
      return w;
    end
    c = ctx_of(a, 'h2000, 'h80);
    if (c >= 0) return m_en[c];
    c = ctx_of(a, 'h200000, 'h1000);
    if (c >= 0) return 32'(m_thr[c]);
    c = ctx_of(a, 'h200004, 'h1000);
    if (c >= 0) return 32'(model_winner(c));
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int id = 1; id <= N; id++) begin
      m_prio[id] = 0;
      m_pend[id] = 0;
      m_fly[id]  = 0;
      m_prev[id] = 0;
    end
    for (int c = 0; c < CTX; c++) begin
      m_thr[c] = 0;
      m_en[c]  = '0;
    end
  endtask

  task automatic model_update(input logic [23:0] a, input logic [31:0] d, input logic [3:0] wen,
                              input logic ren, input logic [N-1:0] s);
    int ct;
    int claim_id;
    int comp_id;
    int c;
    int ai;
    ai       = int'(a);
    ct       = ctx_of(a, 'h200004, 'h1000);
    claim_id = (ren && ct >= 0) ? model_winner(ct) : 0;
    comp_id  = (wen[0] && ct >= 0) ? int'(d[5:0]) : 0;
    for (int id = 1; id <= N; id++) begin
`ifdef PLIC_EDGE_TRIG_EN
      if (s[id-1] && !m_prev[id] && !m_fly[id]) m_pend[id] = 1;
`else
      if (s[id-1] && !m_fly[id]) m_pend[id] = 1;
`endif
      m_prev[id] = s[id-1];
    end
    if (comp_id >= 1 && comp_id <= N && m_fly[comp_id]) m_fly[comp_id] = 0;
    if (claim_id != 0) begin
      m_pend[claim_id] = 0;
      m_fly[claim_id]  = 1;
    end
    if (wen[0] && a[1:0] == 2'b00 && ai >= 4 && ai <= 4 * N) m_prio[ai/4] = int'(d[PRIO_W-1:0]);
    c = ctx_of(a, 'h2000, 'h80);
    if (c >= 0) begin
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) m_en[c][8*b +: 8] = d[8*b +: 8];
      end
    end
    c = ctx_of(a, 'h200000, 'h1000);
    if (c >= 0 && wen[0]) m_thr[c] = int'(d[PRIO_W-1:0]);
  endtask

  // One clock: predict from pre-edge state, advance the model, compare just after the edge.
  task automatic step();
    logic [CTX-1:0] exp_ex;
    logic [31:0]    exp_rd;
    logic [31:0]    ca;
    logic [31:0]    cd;
    logic [3:0]     cwe;
    logic           cre;
    logic [N-1:0]   cs;
    for (int c = 0; c < CTX; c++) exp_ex[c] = (model_winner(c) != 0);
    ca     = addr;
    cd     = wdata;
    cwe    = we;
    cre    = re;
    cs     = src;
    exp_rd = model_read(ca[23:0]);
    @(posedge clk);
    model_update(ca[23:0], cd, cwe, cre, cs);
    #1;
    check("ex_int", 32'(ex_int), 32'(exp_ex));
    if (cre) check("rdata", rdata, exp_rd);
  endtask

  task automatic idle();
    step();
  endtask

  task automatic bus_wr(input int a, input logic [31:0] d, input logic [3:0] wen);
    addr  = a;
    wdata = d;
    we    = wen;
    re    = 1'b0;
    step();
    addr  = '0;
    wdata = '0;
    we    = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    re   = 1'b1;
    we   = '0;
    step();
    d    = rdata;
    re   = 1'b0;
    addr = '0;
  endtask

  task automatic rst_apply();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_ex_int", 32'(ex_int), 32'h0);
    check("rst_async_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_ex_int", 32'(ex_int), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int          op;
    int          idx;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    addr  = '0;
    wdata = '0;
    we    = '0;
    re    = 1'b0;
    src   = '0;
    model_reset();
    #1;
    check("rst_ex_int", 32'(ex_int), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Every mapped register reads 0 after reset; a few unmapped addresses too.
    for (int id = 0; id <= N + 1; id++) bus_rd(prio_addr(id), d);
    bus_rd('h1000, d);
    check("rst_pending", d, 32'h0);
    for (int c = 0; c < CTX; c++) begin
      bus_rd(en_addr(c), d);
      bus_rd(thr_addr(c), d);
      bus_rd(clm_addr(c), d);
      check("rst_claim", d, 32'h0);
    end
    bus_rd('h3000, d);
    bus_rd('h200008, d);
    bus_rd('h2001, d);

    // Two equal-priority sources: claims return 5, then 9, then none.
    bus_wr(prio_addr(5), 3, 4'h1);
    bus_wr(prio_addr(9), 3, 4'h1);
    bus_wr(en_addr(0), 32'h110, 4'hF);
    bus_wr(thr_addr(0), 1, 4'h1);
    src[4] = 1'b1;
    src[8] = 1'b1;
    idle();
    check("exint_1edge", 32'(ex_int[0]), 32'h0);
    src = '0;
    idle();
    check("exint_2edge", 32'(ex_int[0]), 32'h1);
    bus_rd(clm_addr(0), d);
    check("claim_first", d, 32'd5);
    bus_rd(clm_addr(0), d);
    check("claim_second", d, 32'd9);
    bus_rd(clm_addr(0), d);
    check("claim_third", d, 32'd0);
    idle();
    check("exint_drop", 32'(ex_int), 32'h0);
    bus_wr(clm_addr(0), 5, 4'h1);
    bus_wr(clm_addr(0), 9, 4'h1);

    // Threshold gating takes effect one edge after the write.
    src[4] = 1'b1;
    idle();
    src[4] = 1'b0;
    idle();
    bus_wr(thr_addr(0), 3, 4'h1);
    idle();
    check("thr_block", 32'(ex_int[0]), 32'h0);
    bus_wr(thr_addr(0), 2, 4'h1);
    idle();
    check("thr_open", 32'(ex_int[0]), 32'h1);
    bus_rd(clm_addr(0), d);
    check("thr_claim", d, 32'd5);
    bus_wr(clm_addr(0), 5, 4'h1);

    // Source held high across claim and complete.
    src[4] = 1'b1;
    idle();
    idle();
    bus_rd(clm_addr(0), d);
    check("hold_claim", d, 32'd5);
    idle();
    bus_rd('h1000, d);
    check("hold_blocked", d, 32'h0);
    bus_wr(clm_addr(0), 5, 4'h1);
    idle();
    bus_rd('h1000, d);
`ifndef PLIC_EDGE_TRIG_EN
    check("hold_repend", d, 32'h10);
`endif
    bus_wr(clm_addr(0), 7, 4'h1);
    bus_rd('h1000, d);
`ifndef PLIC_EDGE_TRIG_EN
    check("complete_idle_id", d, 32'h10);
`endif
    src[4] = 1'b0;
    bus_rd(clm_addr(0), d);
    bus_wr(clm_addr(0), 5, 4'h1);

    // One source enabled in both contexts: only the first claim gets it.
    bus_wr(prio_addr(12), 1, 4'h1);
    bus_wr(en_addr(0), 32'h800, 4'hF);
    bus_wr(en_addr(1), 32'h800, 4'hF);
    bus_wr(thr_addr(0), 0, 4'h1);
    bus_wr(thr_addr(1), 0, 4'h1);
    src[11] = 1'b1;
    idle();
    src[11] = 1'b0;
    idle();
    bus_rd(clm_addr(1), d);
    check("xctx_claim1", d, 32'd12);
    bus_rd(clm_addr(0), d);
    check("xctx_claim0", d, 32'd0);
    bus_wr(clm_addr(0), 12, 4'h1);

`ifdef PLIC_EDGE_TRIG_EN
    bus_wr(prio_addr(3), 2, 4'h1);
    bus_wr(en_addr(0), 32'h804, 4'hF);
    src[2] = 1'b1;
    repeat (10) idle();
    bus_rd(clm_addr(0), d);
    check("edge_claim", d, 32'd3);
    bus_rd(clm_addr(0), d);
    check("edge_single", d, 32'd0);
    src[2] = 1'b0;
    idle();
    src[2] = 1'b1;
    idle();
    src[2] = 1'b0;
    bus_wr(clm_addr(0), 3, 4'h1);
    bus_rd('h1000, d);
    check("edge_dropped", d, 32'h0);
    src[2] = 1'b1;
    idle();
    idle();
    bus_rd('h1000, d);
    check("edge_repend", d, 32'h4);
    src[2] = 1'b0;
    bus_rd(clm_addr(0), d);
    bus_wr(clm_addr(0), 3, 4'h1);
`endif

    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, N - 1);
        src[idx] = ~src[idx];
      end
      if (it == 800) begin
        addr = clm_addr(0);
        re   = 1'b1;
        rst_apply();
        re   = 1'b0;
        addr = '0;
      end
      op = $urandom_range(0, 7);
      case (op)
        0: bus_wr(prio_addr($urandom_range(0, N + 2)), $urandom, 4'($urandom));
        1: bus_wr(en_addr($urandom_range(0, CTX)), $urandom, 4'($urandom));
        2: bus_wr(thr_addr($urandom_range(0, CTX)), $urandom_range(0, 7), 4'($urandom));
        3, 4: bus_rd(clm_addr($urandom_range(0, CTX)), d);
        5: bus_wr(clm_addr($urandom_range(0, CTX)), {$urandom_range(0, 3), 24'h0,
                  2'b00, 6'($urandom_range(0, 40))}, {3'($urandom), 1'($urandom_range(0, 7) != 0)});
        6: begin
          case ($urandom_range(0, 5))
            0:       d = prio_addr($urandom_range(0, N + 2));
            1:       d = 'h1000;
            2:       d = en_addr($urandom_range(0, CTX));
            3:       d = thr_addr($urandom_range(0, CTX));
            4:       d = $urandom & 32'h0020_3FFF;
            default: d = $urandom;
          endcase
          d[31:24] = 8'($urandom);
          bus_rd(d, d);
        end
        default: idle();
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
